// File: rtl/fir_pkg.sv
// Shared definitions for the FIR stream capture block: state encoding and default widths.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_e;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DEPTH_DEF      = 1024;

  // RAM ports are byte addressed; a word index is shifted left by this much.
  localparam int BYTE_SHIFT = 2;

endpackage

// File: rtl/fir_capture_rd_port.sv
// Readback port: gates host read requests, forms the RAM byte address and
// presents the synchronous RAM output with a one-cycle rd_valid and a held copy.
module fir_capture_rd_port
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int pDATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              rd_req_i,
  input  logic                              rd_allow_i,
  input  logic [pADDR_WIDTH-BYTE_SHIFT-1:0] rd_idx_i,
  input  logic [pDATA_WIDTH-1:0]            ram_do_i,
  output logic                              rd_fire_o,
  output logic [pADDR_WIDTH-1:0]            rd_addr_o,
  output logic                              rd_valid_o,
  output logic [pDATA_WIDTH-1:0]            rd_data_o
);

  logic                   rdValid_q;
  logic [pDATA_WIDTH-1:0] rdHold_q;

  assign rd_fire_o = rd_req_i && rd_allow_i;
  assign rd_addr_o = {rd_idx_i, {BYTE_SHIFT{1'b0}}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdValid_q <= 1'b0;
      rdHold_q  <= '0;
    end else begin
      rdValid_q <= rd_fire_o;
      if (rdValid_q) begin
        rdHold_q <= ram_do_i;
      end
    end
  end

  // The RAM output is only meaningful in the cycle after the read; afterwards the captured copy is shown.
  assign rd_valid_o = rdValid_q;
  assign rd_data_o  = rdValid_q ? ram_do_i : rdHold_q;

endmodule

// File: rtl/fir_sm_capture.sv
// Sink for the FIR AXI-Stream output: writes samples into a result RAM, checks frame
// length/tlast, then offers word readback. Define FIR_CAPTURE_CHECKSUM_EN for a running checksum output.
module fir_sm_capture
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int pDATA_WIDTH = DATA_WIDTH_DEF,
  parameter int pDEPTH      = DEPTH_DEF
) (
  input  logic                              axis_clk,
  input  logic                              axis_rst,
  input  logic                              start,
  input  logic [31:0]                       data_length,
  input  logic                              sm_tvalid,
  input  logic [pDATA_WIDTH-1:0]            sm_tdata,
  input  logic                              sm_tlast,
  output logic                              sm_tready,
  output logic [3:0]                        res_WE,
  output logic                              res_EN,
  output logic [pDATA_WIDTH-1:0]            res_Di,
  output logic [pADDR_WIDTH-1:0]            res_A,
  input  logic [pDATA_WIDTH-1:0]            res_Do,
  output logic                              busy,
  output logic                              done,
  output logic [31:0]                       count,
  output logic                              err_early_last,
  output logic                              err_missing_last,
  output logic                              err_overflow,
  input  logic                              rd_req,
  input  logic [pADDR_WIDTH-BYTE_SHIFT-1:0] rd_idx,
  output logic                              rd_valid,
  output logic [pDATA_WIDTH-1:0]            rd_data
`ifdef FIR_CAPTURE_CHECKSUM_EN
  ,
  output logic [31:0]                       checksum
`endif
);

  cap_state_e  state_q;
  logic [31:0] frameLen_q;
  logic [31:0] count_q;
  logic        done_q;
  logic        errEarly_q;
  logic        errMissing_q;
  logic        errOverflow_q;

  logic                   handshake;
  logic                   inRange;
  logic                   wrFire;
  logic                   rdAllow;
  logic                   rdFire;
  logic [31:0]            countNext;
  logic [pADDR_WIDTH-1:0] wrAddr;
  logic [pADDR_WIDTH-1:0] rdAddr;

  assign sm_tready = (state_q == CAPTURE);
  assign busy      = (state_q == CAPTURE);
  assign handshake = sm_tvalid && sm_tready && !axis_rst;
  assign inRange   = (count_q < 32'(pDEPTH));
  assign wrFire    = handshake && inRange;
  assign countNext = count_q + 32'd1;
  assign wrAddr    = {count_q[pADDR_WIDTH-BYTE_SHIFT-1:0], {BYTE_SHIFT{1'b0}}};

  // A start in the same cycle takes priority, so the read is dropped.
  assign rdAllow = (state_q != CAPTURE) && !start && !axis_rst;

  fir_capture_rd_port #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .pDATA_WIDTH (pDATA_WIDTH)
  ) u_rd_port (
    .clk_i      (axis_clk),
    .rst_i      (axis_rst),
    .rd_req_i   (rd_req),
    .rd_allow_i (rdAllow),
    .rd_idx_i   (rd_idx),
    .ram_do_i   (res_Do),
    .rd_fire_o  (rdFire),
    .rd_addr_o  (rdAddr),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data)
  );

  always_comb begin
    res_EN = 1'b0;
    res_WE = 4'h0;
    res_A  = '0;
    res_Di = '0;
    if (wrFire) begin
      res_EN = 1'b1;
      res_WE = 4'hF;
      res_A  = wrAddr;
      res_Di = sm_tdata;
    end else if (rdFire) begin
      res_EN = 1'b1;
      res_A  = rdAddr;
    end
  end

`ifdef FIR_CAPTURE_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      checksum_q <= '0;
    end else if ((state_q != CAPTURE) && start) begin
      checksum_q <= '0;
    end else if (handshake) begin
      checksum_q <= checksum_q + 32'(sm_tdata);
    end
  end

  assign checksum = checksum_q;
`endif

  // A zero-length frame skips CAPTURE entirely so no sample can reach the RAM.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q       <= IDLE;
      frameLen_q    <= '0;
      count_q       <= '0;
      done_q        <= 1'b0;
      errEarly_q    <= 1'b0;
      errMissing_q  <= 1'b0;
      errOverflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            frameLen_q    <= data_length;
            count_q       <= '0;
            errEarly_q    <= 1'b0;
            errMissing_q  <= 1'b0;
            errOverflow_q <= 1'b0;
            if (data_length == 32'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= CAPTURE;
              done_q  <= 1'b0;
            end
          end
        end
        CAPTURE: begin
          if (handshake) begin
            count_q <= countNext;
            if (!inRange) begin
              errOverflow_q <= 1'b1;
            end
            if (sm_tlast && (countNext < frameLen_q)) begin
              errEarly_q <= 1'b1;
              state_q    <= DONE;
              done_q     <= 1'b1;
            end else if (!sm_tlast && (countNext == frameLen_q)) begin
              errMissing_q <= 1'b1;
              state_q      <= DONE;
              done_q       <= 1'b1;
            end else if (sm_tlast && (countNext == frameLen_q)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done             = done_q;
  assign count            = count_q;
  assign err_early_last   = errEarly_q;
  assign err_missing_last = errMissing_q;
  assign err_overflow     = errOverflow_q;

endmodule
